// File: rtl/div_period_monitor.sv
// Measures high/low phase lengths of the divider toggle output and reports them over valid/ready.
// Optional DIV_MON_CHECK_EN builds the half-period comparator behind the sticky err flag.
module div_period_monitor #(
    parameter int CNT_W    = 30,
    parameter int EXP_HALF = 10,
    parameter int TOL      = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W-1:0] meas_low,
    output logic             overrun,
    output logic             sat,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic             div_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_len;
    logic [CNT_W-1:0] cnt_inc;
    logic             rise;
    logic             fall;
    logic             complete;
    logic             load;

    // div_in already lives in the clk domain, so a single delay flop is enough for edge detect
    assign rise     = div_in & ~div_q;
    assign fall     = ~div_in & div_q;
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    assign complete = (state == LOW) & rise;
    assign load     = complete & (~meas_valid | meas_ready);
    assign sat      = (state != IDLE) & (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            div_q  <= 1'b0;
            cnt    <= '0;
            hi_len <= '0;
        end else begin
            div_q <= div_in;
            case (state)
                IDLE: begin
                    if (rise) begin
                        cnt   <= CNT_ONE;
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        hi_len <= cnt;
                        cnt    <= CNT_ONE;
                        state  <= LOW;
                    end else if (div_in) begin
                        cnt <= cnt_inc;
                    end
                end
                LOW: begin
                    if (rise) begin
                        cnt   <= CNT_ONE;
                        state <= HIGH;
                    end else if (!div_in) begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A completion that finds the holding register busy is dropped, never queued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meas_valid <= 1'b0;
            meas_high  <= '0;
            meas_low   <= '0;
            overrun    <= 1'b0;
        end else if (load) begin
            meas_valid <= 1'b1;
            meas_high  <= hi_len;
            meas_low   <= cnt;
        end else if (complete) begin
            overrun <= 1'b1;
        end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
        end
    end

`ifdef DIV_MON_CHECK_EN
    localparam logic [CNT_W-1:0] EXP_V = CNT_W'(EXP_HALF);
    localparam logic [CNT_W-1:0] TOL_V = CNT_W'(TOL);

    function automatic logic off_band(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] diff;
        diff = (v >= EXP_V) ? v - EXP_V : EXP_V - v;
        return diff > TOL_V;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (load && (off_band(hi_len) || off_band(cnt))) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{EXP_HALF, TOL};
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_div_period_monitor.sv
// Directed bench for div_period_monitor: a queue of expected reports is filled as periods are
// driven and drained on every handshake transfer; a CNT_W=4 instance covers counter saturation.
module tb_div_period_monitor;

`ifdef DIV_MON_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        div_in;
    logic        meas_ready;
    logic        meas_valid;
    logic [29:0] meas_high;
    logic [29:0] meas_low;
    logic        overrun;
    logic        sat;
    logic        err;

    logic        div4;
    logic        ready4;
    logic        valid4;
    logic [3:0]  high4;
    logic [3:0]  low4;
    logic        overrun4;
    logic        sat4;
    logic        err4;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    logic [63:0] sb[$];

    div_period_monitor dut (
        .clk(clk), .reset(reset), .div_in(div_in), .meas_ready(meas_ready),
        .meas_valid(meas_valid), .meas_high(meas_high), .meas_low(meas_low),
        .overrun(overrun), .sat(sat), .err(err)
    );

    div_period_monitor #(.CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .div_in(div4), .meas_ready(ready4),
        .meas_valid(valid4), .meas_high(high4), .meas_low(low4),
        .overrun(overrun4), .sat(sat4), .err(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int h, input int l);
        sb.push_back({32'(h), 32'(l)});
    endtask

    // One clock: drive inputs, and if a transfer happens on this edge, score it against the queue
    task automatic step(input logic d, input logic d4);
        logic        xfer;
        logic [31:0] h;
        logic [31:0] l;
        logic [63:0] e;
        div_in = d;
        div4   = d4;
        xfer   = meas_valid & meas_ready;
        h      = 32'(meas_high);
        l      = 32'(meas_low);
        @(posedge clk);
        #1;
        if (xfer) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_high", h, e[63:32]);
                chk("sb_low", l, e[31:0]);
            end
        end
    endtask

    task automatic drive(input logic d, input int n);
        for (int i = 0; i < n; i++) step(d, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        div_in     = 1'b0;
        div4       = 1'b0;
        meas_ready = 1'b1;
        ready4     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(meas_valid), 0);
        chk("rst_high", 32'(meas_high), 0);
        chk("rst_low", 32'(meas_low), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_sat", 32'(sat), 0);
        chk("rst_err", 32'(err), 0);
        reset = 1'b0;

        // divider-like toggling every 10 cycles, leading partial low is discarded
        drive(0, 3);
        push(10, 10);
        drive(1, 10);
        drive(0, 10);
        chk("pre_first_valid", 32'(meas_valid), 0);
        drive(1, 1);
        chk("first_valid", 32'(meas_valid), 1);
        chk("first_high", 32'(meas_high), 10);
        chk("first_low", 32'(meas_low), 10);
        push(10, 10);
        drive(1, 9);
        drive(0, 10);
        drive(1, 1);
        chk("second_valid", 32'(meas_valid), 1);
        chk("div_overrun", 32'(overrun), 0);
        chk("div_err", 32'(err), 0);

        // 3 high / 5 low
        push(3, 5);
        drive(1, 2);
        drive(0, 5);
        drive(1, 1);
        chk("short_valid", 32'(meas_valid), 1);
        chk("short_high", 32'(meas_high), 3);
        chk("short_low", 32'(meas_low), 5);
        chk("short_err", 32'(err), 32'(CHK));

        // ready pulsed on the completing cycle: old result leaves, new one loads
        meas_ready = 1'b0;
        drive(1, 9);
        drive(0, 10);
        chk("hold_short_high", 32'(meas_high), 3);
        meas_ready = 1'b1;
        push(10, 10);
        drive(1, 1);
        chk("same_cyc_valid", 32'(meas_valid), 1);
        chk("same_cyc_high", 32'(meas_high), 10);
        chk("same_cyc_low", 32'(meas_low), 10);
        chk("same_cyc_overrun", 32'(overrun), 0);

        // two completions with ready low: second (4/6) is dropped
        drive(1, 9);
        meas_ready = 1'b0;
        push(10, 10);
        drive(0, 10);
        drive(1, 1);
        drive(1, 3);
        drive(0, 6);
        drive(1, 1);
        chk("ovr_valid", 32'(meas_valid), 1);
        chk("ovr_high", 32'(meas_high), 10);
        chk("ovr_low", 32'(meas_low), 10);
        chk("ovr_overrun", 32'(overrun), 1);
        meas_ready = 1'b1;
        step(1, 0);
        chk("ovr_drain_valid", 32'(meas_valid), 0);

        // asynchronous reset in the middle of a high phase
        drive(1, 3);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(meas_valid), 0);
        chk("arst_high", 32'(meas_high), 0);
        chk("arst_low", 32'(meas_low), 0);
        chk("arst_overrun", 32'(overrun), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_sat", 32'(sat), 0);
        @(posedge clk);
        #1;
        div_in = 1'b0;
        reset  = 1'b0;
        drive(0, 4);
        push(10, 10);
        drive(1, 10);
        drive(0, 10);
        drive(1, 1);
        chk("post_rst_valid", 32'(meas_valid), 1);
        chk("post_rst_high", 32'(meas_high), 10);
        chk("post_rst_low", 32'(meas_low), 10);
        chk("post_rst_err", 32'(err), 0);

        // 4-bit counter held high for 20 cycles
        for (int i = 1; i <= 20; i++) begin
            step(1, 1);
            if (i == 14) chk("sat4_before", 32'(sat4), 0);
            if (i == 15) chk("sat4_at15", 32'(sat4), 1);
        end
        chk("sat4_held", 32'(sat4), 1);
        for (int i = 0; i < 3; i++) step(1, 0);
        chk("sat4_low", 32'(sat4), 0);
        step(1, 1);
        chk("sat4_valid", 32'(valid4), 1);
        chk("sat4_high", 32'(high4), 15);
        chk("sat4_low_len", 32'(low4), 3);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/div_period_monitor.md
# div_period_monitor

Period monitor that sits directly downstream of the parametric clock divider. It consumes the divider's toggle output, which is synchronous to `clk`. For each full period it measures the high and low phase lengths in `clk` cycles and reports them over a valid/ready handshake. In checked builds it also flags any deviation from the expected half-period. It serves both as a self-check in the top level and as a measurement source for the bench.

## Interface
Parameters:
- CNT_W, 30: width of the phase counters and reported lengths. Matches the divider counter width.
- EXP_HALF, 10: expected length of each phase in `clk` cycles. 10 corresponds to divider Limit 9.
- TOL, 0: allowed absolute deviation from EXP_HALF before `err` sets.

Ports:
- clk, input, 1: sole clock. All logic is on the rising edge.
- reset, input, 1: asynchronous, active-high; clears all state.
- div_in, input, 1: divided clock from the divider toggle flop. Synchronous to `clk`, so it gets no synchronizer.
- meas_ready, input, 1: consumer accepts the current measurement.
- meas_valid, output, 1: measurement available.
- meas_high, output, CNT_W: high-phase length in cycles.
- meas_low, output, CNT_W: low-phase length in cycles.
- overrun, output, 1: sticky; a completed measurement was dropped.
- sat, output, 1: the running phase counter is at all-ones.
- err, output, 1: sticky; a reported phase length fell outside EXP_HALF±TOL.

## Operation
- div_q is a one-cycle registered copy of div_in.
  - rise = div_in & ~div_q.
  - fall = ~div_in & div_q.
- FSM states are IDLE, HIGH and LOW. Reset enters IDLE.
- IDLE:
  - Ignores everything except rise, so the first partial phase is always discarded.
  - On rise: cnt <= 1, go to HIGH.
- HIGH:
  - While div_in = 1: cnt increments, saturating at 2^CNT_W-1.
  - On fall: hi_len <= cnt, cnt <= 1, go to LOW.
- LOW:
  - While div_in = 0: cnt increments, saturating.
  - On rise: a measurement completes with (hi_len, cnt). Then cnt <= 1, go to HIGH.
- cnt therefore equals the number of cycles div_in has been at its current level.
- sat = (cnt == all-ones) in HIGH or LOW. A saturated length is reported as all-ones.
- Completion with the output register free, or freed in the same cycle (meas_valid & meas_ready): load meas_high/meas_low and set meas_valid.
- Completion while meas_valid & ~meas_ready:
  - The new result is dropped.
  - The held result is unchanged.
  - overrun sets.
- meas_valid clears on meas_valid & meas_ready with no simultaneous completion.
- While meas_valid & ~meas_ready, meas_high and meas_low hold stable.
- overrun and err clear only on reset.

## Timing
- Reset values:
  - meas_valid, meas_high, meas_low, overrun, sat, err = 0.
  - State = IDLE; div_q = 0; cnt = 0; hi_len = 0.
- If div_in = 1 in the first cycle after reset release, div_q = 0 makes that a rise, and measurement starts from it.
- A rise seen in cycle k leaves meas_valid = 1 from cycle k+1. Latency is one cycle from the completing edge.
- For the divider with Limit 9, div_in toggles every 10 cycles:
  - The first report is meas_high = 10, meas_low = 10.
  - It arrives 21 cycles after the first rise.
  - A new report follows every 20 cycles.
- Handshake: transfer happens on a cycle with meas_valid & meas_ready. meas_ready may be held high permanently.
- Reset asserted mid-phase or mid-handshake:
  - Outputs clear immediately, without waiting for `clk`.
  - Any pending measurement is lost.
  - The next report needs one full period after the first rise.
- A level pulse one cycle long is valid and measures 1.

## Configuration
- DIV_MON_CHECK_EN defined:
  - On each load, err sets if |meas_high − EXP_HALF| > TOL or |meas_low − EXP_HALF| > TOL.
  - Dropped results are not checked.
- DIV_MON_CHECK_EN undefined:
  - No comparator logic is built and `err` is tied to 0.
  - EXP_HALF and TOL are unused.

## Test plan
- Divider (Limit 9) drives div_in, meas_ready = 1 → reports of 10/10 every 20 cycles; first report 21 cycles after the first rise; overrun = err = 0.
- div_in = 1 for 3 cycles, 0 for 5, then rises → meas_high = 3, meas_low = 5 one cycle after that rise; with DIV_MON_CHECK_EN, err = 1.
- meas_ready = 0 across two completions → the first result is held unchanged, overrun = 1; then meas_ready = 1 for one cycle → meas_valid drops.
- meas_ready pulsed in the same cycle a completion occurs → the new result is loaded, meas_valid stays 1, overrun = 0.
- Reset pulse in the middle of a HIGH phase → all outputs are 0 at once; the following partial phase is discarded; the first new report is a full 10/10.
- CNT_W = 4, div_in held high for 20 cycles → sat = 1 from cycle 15; the report gives meas_high = 15.
